// File: rtl/mem_pkg.sv
// Shared types and constants for the burst master and its read stage.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Cycles from mem_addr to valid mem_q; the read stage is built for exactly one.
    localparam int RD_LATENCY = 1;

endpackage

// File: rtl/mem_rd_stage.sv
// Read issue/deliver pipeline: issues RAM addresses one cycle ahead of delivery
// and re-presents the pending address while the consumer stalls.
module mem_rd_stage
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  active,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  rd_ready,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   C_ONE = 1;

    if (RD_LATENCY != 1) begin : g_lat_check
        $error("mem_rd_stage supports a RAM read latency of 1 only");
    end

    logic [ADDR_WIDTH-1:0] issue_addr, pend_addr;
    logic [ADDR_WIDTH:0]   issue_cnt, deliver_cnt;
    logic                  pending;
    logic                  stall, issue, hs;

    assign stall    = pending & ~rd_ready;
    assign issue    = active & (issue_cnt != '0) & ~stall;
    assign hs       = active & pending & rd_ready;
    assign rd_valid = active & pending;
    assign rd_data  = mem_q;
    assign rd_addr  = stall ? pend_addr : issue_addr;
    assign last     = hs & (deliver_cnt == C_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_addr  <= '0;
            pend_addr   <= '0;
            issue_cnt   <= '0;
            deliver_cnt <= '0;
            pending     <= 1'b0;
        end else if (load) begin
            issue_addr  <= start_addr;
            issue_cnt   <= len;
            deliver_cnt <= len;
            pending     <= 1'b0;
        end else begin
            if (issue) begin
                pending    <= 1'b1;
                pend_addr  <= issue_addr;
                issue_addr <= issue_addr + A_ONE;
                issue_cnt  <= issue_cnt - C_ONE;
            end else if (hs) begin
                pending <= 1'b0;
            end
            if (hs)
                deliver_cnt <= deliver_cnt - C_ONE;
        end
    end

endmodule

// File: rtl/mem_burst_master.sv
// Burst initiator for a single-port synchronous RAM: command FSM and write path,
// with reads delegated to mem_rd_stage.
module mem_burst_master
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   C_ONE = 1;

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] addr, rd_addr;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  accept, wr_hs, rd_last, rd_vld;

    assign accept   = cmd_valid & (state == IDLE);
    assign wr_hs    = (state == WRITE) & wr_valid;
    assign mem_data = wr_data;

    mem_rd_stage #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_rd (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .active    (state == READ),
        .start_addr(cmd_addr),
        .len       (cmd_len),
        .rd_ready  (rd_ready),
        .mem_q     (mem_q),
        .rd_valid  (rd_vld),
        .rd_data   (rd_data),
        .rd_addr   (rd_addr),
        .last      (rd_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (cmd_valid) begin
                if (cmd_len == '0)  next_state = DONE;
                else if (cmd_write) next_state = WRITE;
                else                next_state = READ;
            end
            WRITE: if (wr_valid && cnt == C_ONE) next_state = DONE;
            READ:  if (rd_last) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        done      = (state == DONE);
        wr_ready  = (state == WRITE);
        mem_we    = wr_hs;
        rd_valid  = rd_vld;
        mem_addr  = (state == READ) ? rd_addr : addr;
    end

    // Write-path address/count; the read stage keeps its own copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            cnt  <= '0;
        end else if (accept) begin
            addr <= cmd_addr;
            cnt  <= cmd_len;
        end else if (wr_hs) begin
            addr <= addr + A_ONE;
            cnt  <= cnt - C_ONE;
        end
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// Self-checking bench for mem_burst_master: vector table, directed corner
// sequences and randomized bursts against a word-array reference model.
module tb_mem_burst_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [8:0]  cmd_len = '0;
    logic [15:0] wr_data = '0, rd_data, mem_data, mem_q;
    logic        wr_valid = 1'b0, wr_ready, rd_valid, rd_ready = 1'b0;
    logic [7:0]  mem_addr;
    logic        mem_we, busy, done;

    logic [15:0] ram   [0:255];
    logic [15:0] model [0:255];
    logic [15:0] wbuf  [0:255];
    logic        pre = 1'b1;
    int          vec = 0, miss = 0;

    always #5 clk = ~clk;

    mem_burst_master #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .mem_q(mem_q), .busy(busy), .done(done)
    );

    // Registered-address RAM
    always @(posedge clk) begin
        if (pre) begin
            for (int i = 0; i < 256; i++) ram[i] <= 16'hA000 + 16'(i);
        end else begin
            if (mem_we) ram[mem_addr] <= mem_data;
            mem_q <= ram[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // mode: 0 no backpressure, 1 random, 2 wr_valid gap at t=1, 3 rd_ready low t=1..3
    task automatic run_burst(input bit wr, input logic [7:0] a, input int len,
                             input int mode, input int exp_busy);
        int t, idx, last_t, nbusy, w;
        bit seen;
        w = 0;
        while (!cmd_ready && w < 100) begin @(posedge clk); #1; w++; end
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = 9'(len);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        idx = 0; last_t = -1; nbusy = 0; seen = 1'b0;
        for (t = 0; t < 3000 && !seen; t++) begin
            if (wr) begin
                wr_valid = (mode == 1) ? ($urandom % 4 != 0) : (mode == 2) ? (t != 1) : 1'b1;
                wr_data  = wbuf[8'(idx)];
            end else begin
                rd_ready = (mode == 1) ? ($urandom % 4 != 0) : (mode == 3) ? !(t >= 1 && t <= 3) : 1'b1;
            end
            #1;
            if (busy) nbusy++;
            if (done) begin
                seen = 1'b1;
                chk("done_time", t, last_t + 1);
                chk("done_quiet", {29'd0, mem_we, rd_valid, wr_ready}, 32'd0);
            end else begin
                chk("wr_ready", {31'd0, wr_ready}, {31'd0, wr});
                chk("mem_we", {31'd0, mem_we}, {31'd0, wr & wr_valid});
                chk("rd_valid", {31'd0, rd_valid}, {31'd0, !wr && t >= 1 && idx < len});
                if (mode == 3 && t >= 1 && t <= 3) begin
                    chk("stall_data", {16'd0, rd_data}, {16'd0, 16'hA000 + 16'(a)});
                    chk("stall_addr", {24'd0, mem_addr}, {24'd0, a});
                end
                if (wr && wr_valid && wr_ready) begin
                    model[8'(a + 8'(idx))] = wr_data;
                    idx++; last_t = t;
                end
                if (!wr && rd_valid && rd_ready) begin
                    chk("rd_data", {16'd0, rd_data}, {16'd0, model[8'(a + 8'(idx))]});
                    idx++; last_t = t;
                end
            end
            @(posedge clk); #1;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        chk("words", idx, len);
        if (exp_busy >= 0) chk("busy_cycles", nbusy, exp_busy);
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
        wr_valid = 1'b0; rd_ready = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        int          len;
        int          mode;
        int          exp_busy;
        logic [15:0] d0, d1, d2;
    } vec_t;

    vec_t tbl [0:8];

    initial begin
        tbl[0] = '{1'b0, 8'h10, 4,   0, 6,  16'h0, 16'h0, 16'h0};
        tbl[1] = '{1'b1, 8'h20, 3,   2, 5,  16'h1111, 16'h2222, 16'h3333};
        tbl[2] = '{1'b0, 8'h20, 3,   0, 5,  16'h0, 16'h0, 16'h0};
        tbl[3] = '{1'b0, 8'h40, 3,   3, 8,  16'h0, 16'h0, 16'h0};
        tbl[4] = '{1'b0, 8'hFE, 4,   0, 6,  16'h0, 16'h0, 16'h0};
        tbl[5] = '{1'b0, 8'h00, 0,   0, 1,  16'h0, 16'h0, 16'h0};
        tbl[6] = '{1'b1, 8'h30, 0,   0, 1,  16'h0, 16'h0, 16'h0};
        tbl[7] = '{1'b1, 8'h80, 256, 1, -1, 16'h0, 16'h0, 16'h0};
        tbl[8] = '{1'b0, 8'h80, 256, 1, -1, 16'h0, 16'h0, 16'h0};
        for (int i = 0; i < 256; i++) model[i] = 16'hA000 + 16'(i);

        @(posedge clk); #1;
        pre = 1'b0;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_quiet", {27'd0, busy, done, wr_ready, rd_valid, mem_we}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 9; v++) begin
            for (int i = 0; i < 256; i++) wbuf[i] = 16'($urandom);
            if (tbl[v].len <= 3) begin
                wbuf[0] = tbl[v].d0; wbuf[1] = tbl[v].d1; wbuf[2] = tbl[v].d2;
            end
            run_burst(tbl[v].wr, tbl[v].addr, tbl[v].len, tbl[v].mode, tbl[v].exp_busy);
            if (v == 1) begin
                chk("ram_20", {16'd0, ram[8'h20]}, 32'h1111);
                chk("ram_22", {16'd0, ram[8'h22]}, 32'h3333);
            end
        end

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 256; i++) wbuf[i] = 16'($urandom);
            run_burst(1'($urandom), 8'($urandom), int'($urandom_range(0, 12)), 1, -1);
        end

        // Reset in the middle of a len=8 write after three accepted words
        for (int i = 0; i < 8; i++) wbuf[i] = 16'($urandom);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h60; cmd_len = 9'd8;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1'b1; wr_data = wbuf[k];
            model[8'h60 + k] = wbuf[k];
            @(posedge clk); #1;
        end
        wr_valid = 1'b1; wr_data = wbuf[3];
        #1;
        chk("pre_rst_we", {31'd0, mem_we}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_we_drop", {31'd0, mem_we}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        wr_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("no_done_after_rst", {31'd0, done}, 32'd0);
        end

        for (int i = 0; i < 256; i++) begin
            vec++;
            if (ram[i] !== model[i]) begin
                miss++;
                $display("FAIL ram_final[%0d]: got %0h expected %0h", i, ram[i], model[i]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
